seg7_scan_driver: RTL and testbench

Two-digit multiplexed 7-segment display driver that consumes the two 4-bit nibbles and ripple-carry outputs of the 8-bit 74163-style counter. It captures the counter value on a latch strobe, then time-multiplexes the low and high nibble as hex digits onto a shared active-low segment bus, with anti-ghosting blanking between digits. A sticky overflow LED records upper-counter carry events. It sits directly downstream of the counter, at the board display pins.

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_decoder.sv | 17 +
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment scan driver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: hex-to-segment table (active-high, bit 0 = a .. bit 6 = g),
// the all-segments-off code for the active-low bus, and the digit-select enum.
package seg7_pkg;

    // All segments dark on the active-low segment bus.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-high g..a patterns, indexed by nibble value.
    // Packed concatenation lists index 15 first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    typedef enum logic {
        DIG_LO = 1'b0,
        DIG_HI = 1'b1
    } digit_sel_e;

endpackage

// File: rtl/seg7_decoder.sv
// Purpose: 4-bit nibble to 7-segment active-low glyph lookup.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   nib_i    [3:0]  nibble to display (0..F)
//   seg_n_o  [6:0]  segments g..a, active-low
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = ~HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: two-digit multiplexed hex display driver with blanking and sticky overflow LED.
// Latency: one cycle from prescaler/select/snapshot state to the registered pins.
// Backpressure: none; free-running scan, inputs sampled every clock.
//
// Ports:
//   clk               system clock, rising edge
//   Reset             asynchronous active-high reset
//   Latch             snapshot strobe (tie high to track the counter continuously)
//   Din_Low  [3:0]    low nibble from the counter
//   Din_High [3:0]    high nibble from the counter
//   Carry    [1:0]    counter carries; only bit 1 feeds the overflow LED
//   Ovf_Clr           synchronous overflow clear (an incoming carry wins)
//   Seg_N    [6:0]    segments g..a, active-low, registered
//   Digit_N  [1:0]    digit enables, active-low, bit 0 = low nibble, registered
//   Ovf_LED           sticky overflow indicator, registered
//
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to keep the high digit dark
// while its snapshot is zero (slot timing is unchanged).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 50000,  // cycles per digit slot, >= 2
    parameter int BLANK    = 500     // dark cycles at slot start, 0 <= BLANK < PRESCALE
)(
    input  logic       clk,
    input  logic       Reset,
    input  logic       Latch,
    input  logic [3:0] Din_Low,
    input  logic [3:0] Din_High,
    input  logic [1:0] Carry,
    input  logic       Ovf_Clr,
    output logic [6:0] Seg_N,
    output logic [1:0] Digit_N,
    output logic       Ovf_LED
);

    localparam int              CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_sel_e       sel_q, sel_d;
    logic [3:0]       snap_lo_q, snap_lo_d;
    logic [3:0]       snap_hi_q, snap_hi_d;
    logic             ovf_q, ovf_d;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [1:0]       digit_n_q, digit_n_d;

    logic             wrap;
    logic             in_blank;
    logic             show_en;
    logic [3:0]       nib_sel;
    logic [6:0]       seg_dec_n;

    // Only the upper counter's carry is meaningful for overflow.
    logic             carry0_unused;
    assign carry0_unused = Carry[0];

    // With no blanking the comparison would be constant, so drop it entirely.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);
            assign in_blank = (cnt_q < BLANK_C);
        end
    endgenerate

    assign wrap    = (cnt_q == CNT_MAX);
    assign nib_sel = (sel_q == DIG_HI) ? snap_hi_q : snap_lo_q;

    seg7_decoder u_dec (
        .nib_i   (nib_sel),
        .seg_n_o (seg_dec_n)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A zero high digit stays dark for its whole SHOW phase.
    assign show_en = !in_blank && !((sel_q == DIG_HI) && (snap_hi_q == 4'h0));
`else
    assign show_en = !in_blank;
`endif

    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        sel_d     = sel_q;
        if (wrap) begin
            sel_d = (sel_q == DIG_LO) ? DIG_HI : DIG_LO;
        end

        // Both nibbles move on the same edge so a mid-slot latch never tears.
        snap_lo_d = Latch ? Din_Low  : snap_lo_q;
        snap_hi_d = Latch ? Din_High : snap_hi_q;

        // Carry has priority over clear so no overflow event is ever lost.
        ovf_d     = Carry[1] ? 1'b1 : (Ovf_Clr ? 1'b0 : ovf_q);

        // Digit enable derives from a single select bit, so at most one is low.
        digit_n_d = 2'b11;
        seg_n_d   = SEG_OFF;
        if (show_en) begin
            digit_n_d = (sel_q == DIG_HI) ? 2'b01 : 2'b10;
            seg_n_d   = seg_dec_n;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q     <= '0;
            sel_q     <= DIG_LO;
            snap_lo_q <= 4'h0;
            snap_hi_q <= 4'h0;
            ovf_q     <= 1'b0;
            seg_n_q   <= SEG_OFF;
            digit_n_q <= 2'b11;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            snap_lo_q <= snap_lo_d;
            snap_hi_q <= snap_hi_d;
            ovf_q     <= ovf_d;
            seg_n_q   <= seg_n_d;
            digit_n_q <= digit_n_d;
        end
    end

    assign Seg_N   = seg_n_q;
    assign Digit_N = digit_n_q;
    assign Ovf_LED = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: directed self-checking bench for seg7_scan_driver (PRESCALE=4, BLANK=1).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Latch;
    logic [3:0] Din_Low;
    logic [3:0] Din_High;
    logic [1:0] Carry;
    logic       Ovf_Clr;
    logic [6:0] Seg_N;
    logic [1:0] Digit_N;
    logic       Ovf_LED;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected active-low glyphs, computed by hand from the standard a..g patterns.
    logic [6:0] segn_tbl [16];

    typedef struct {
        logic       latch;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [1:0] dig;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[$];

    seg7_scan_driver #(.PRESCALE(4), .BLANK(1)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Latch    (Latch),
        .Din_Low  (Din_Low),
        .Din_High (Din_High),
        .Carry    (Carry),
        .Ovf_Clr  (Ovf_Clr),
        .Seg_N    (Seg_N),
        .Digit_N  (Digit_N),
        .Ovf_LED  (Ovf_LED)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] d, input logic [6:0] s);
        n_chk++;
        if (Digit_N !== d || Seg_N !== s) begin
            n_fail++;
            $display("FAIL %s: got Digit_N=%b Seg_N=%h, want Digit_N=%b Seg_N=%h",
                     name, Digit_N, Seg_N, d, s);
        end
    endtask

    task automatic chk_ovf(input string name, input logic e);
        n_chk++;
        if (Ovf_LED !== e) begin
            n_fail++;
            $display("FAIL %s: got Ovf_LED=%b, want %b", name, Ovf_LED, e);
        end
    endtask

    task automatic add_vec(input logic l, input logic [3:0] h, input logic [3:0] lo,
                           input logic [1:0] d, input logic [6:0] s);
        vec_t v;
        v.latch = l;
        v.hi    = h;
        v.lo    = lo;
        v.dig   = d;
        v.seg   = s;
        vecs.push_back(v);
    endtask

    // Assert reset, check reset state, release just after an edge so the
    // following rising edge is edge 1.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk("reset_pins", 2'b11, 7'h7F);
        chk_ovf("reset_ovf", 1'b0);
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        segn_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Edges 1..8: first scan period with 3/A tracked.
        add_vec(1'b1, 4'h3, 4'hA, 2'b11, 7'h7F);
        for (int k = 0; k < 3; k++) add_vec(1'b1, 4'h3, 4'hA, 2'b10, 7'h08);
        add_vec(1'b1, 4'h3, 4'hA, 2'b11, 7'h7F);
        for (int k = 0; k < 3; k++) add_vec(1'b1, 4'h3, 4'hA, 2'b01, 7'h30);
        // Edge 9: capture 5/5, then freeze while inputs go to F/F.
        add_vec(1'b1, 4'h5, 4'h5, 2'b11, 7'h7F);
        for (int k = 0; k < 3; k++) add_vec(1'b0, 4'hF, 4'hF, 2'b10, 7'h12);
        add_vec(1'b0, 4'hF, 4'hF, 2'b11, 7'h7F);
        for (int k = 0; k < 3; k++) add_vec(1'b0, 4'hF, 4'hF, 2'b01, 7'h12);
        add_vec(1'b0, 4'hF, 4'hF, 2'b11, 7'h7F);
        for (int k = 0; k < 3; k++) add_vec(1'b0, 4'hF, 4'hF, 2'b10, 7'h12);
        add_vec(1'b0, 4'hF, 4'hF, 2'b11, 7'h7F);
        for (int k = 0; k < 3; k++) add_vec(1'b0, 4'hF, 4'hF, 2'b01, 7'h12);

        Reset    = 1'b1;
        Latch    = 1'b1;
        Din_High = 4'h3;
        Din_Low  = 4'hA;
        Carry    = 2'b00;
        Ovf_Clr  = 1'b0;
        tick();
        do_reset();

        // Table: edges 1..24 after reset release.
        foreach (vecs[i]) begin
            Latch    = vecs[i].latch;
            Din_High = vecs[i].hi;
            Din_Low  = vecs[i].lo;
            tick();
            chk($sformatf("vec_edge%0d", i + 1), vecs[i].dig, vecs[i].seg);
        end
        chk_ovf("ovf_idle", 1'b0);

        // Sweep all nibbles on the low digit, one full period each
        // (each chunk starts on a low-digit blank edge).
        for (int v = 0; v < 16; v++) begin
            Latch    = 1'b1;
            Din_High = 4'h3;
            Din_Low  = 4'(v);
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k == 2) chk($sformatf("sweep_lo_%0h", v), 2'b10, segn_tbl[v]);
                if (k == 6) chk($sformatf("sweep_hi_%0h", v), 2'b01, segn_tbl[3]);
            end
        end

        // Overflow LED behaviour.
        Carry = 2'b10; tick(); chk_ovf("ovf_set", 1'b1);
        Carry = 2'b00; tick(); chk_ovf("ovf_hold1", 1'b1);
        tick(); chk_ovf("ovf_hold2", 1'b1);
        Ovf_Clr = 1'b1; tick(); chk_ovf("ovf_clr", 1'b0);
        Ovf_Clr = 1'b0;
        Carry = 2'b01; tick(); chk_ovf("carry0_ignored", 1'b0);
        Carry = 2'b10; Ovf_Clr = 1'b1; tick(); chk_ovf("set_wins_from0", 1'b1);
        tick(); chk_ovf("set_wins_from1", 1'b1);
        Carry = 2'b00; Ovf_Clr = 1'b0;

        // Asynchronous reset at cnt=2 of the high-digit slot.
        Latch    = 1'b1;
        Din_High = 4'h3;
        Din_Low  = 4'hA;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            Carry = (k == 2) ? 2'b10 : 2'b00;
            tick();
        end
        chk("pre_reset_hi", 2'b01, 7'h30);
        chk_ovf("pre_reset_ovf", 1'b1);
        Reset = 1'b1;
        #1;
        chk("async_reset_pins", 2'b11, 7'h7F);
        chk_ovf("async_reset_ovf", 1'b0);
        #2;
        Reset = 1'b0;
        tick(); chk("restart_edge1", 2'b11, 7'h7F);
        tick(); chk("restart_edge2_lo", 2'b10, 7'h08);

        // Leading-zero behaviour on the high digit.
        Latch    = 1'b1;
        Din_High = 4'h0;
        Din_Low  = 4'h7;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) chk("lz_lo", 2'b10, 7'h78);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (k == 6) chk("lz_hi_zero", 2'b11, 7'h7F);
`else
            if (k == 6) chk("lz_hi_zero", 2'b01, 7'h40);
`endif
        end
        Din_High = 4'h1;
        for (int k = 9; k <= 14; k++) begin
            tick();
            if (k == 14) chk("lz_hi_one", 2'b01, 7'h79);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
